// File: rtl/lsu_pkg.sv
// Shared types and funct3 encodings for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDone
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Illegal encoding (stores have no unsigned forms) or misaligned address.
    function automatic logic access_error(input logic [2:0] f3, input logic we,
                                          input logic [1:0] off);
        logic err;
        case (f3)
            F3_B:    err = 1'b0;
            F3_H:    err = off[0];
            F3_W:    err = (off != 2'b00);
            F3_BU:   err = we;
            F3_HU:   err = we | off[0];
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables / replicated data, load lane extract and extend.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [31:0] w_shifted;

    always_comb begin
        w_shifted = i_rdata >> {i_offset, 3'b000};
        o_be      = 4'b1111;
        o_wdata   = i_wdata;
        o_rdata   = i_rdata;
        case (i_funct3)
            F3_B: begin
                o_be    = 4'b0001 << i_offset;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{w_shifted[7]}}, w_shifted[7:0]};
            end
            F3_BU: begin
                o_be    = 4'b0001 << i_offset;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {24'h0, w_shifted[7:0]};
            end
            F3_H: begin
                o_be    = 4'b0011 << i_offset;
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = {{16{w_shifted[15]}}, w_shifted[15:0]};
            end
            F3_HU: begin
                o_be    = 4'b0011 << i_offset;
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = {16'h0, w_shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: accepts one aligned access, drives a
// request/ack memory port with a timeout, and reports done/error pulses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ls_valid,
    input  logic        ls_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ls_stall,
    output logic        ls_done,
    output logic [31:0] load_data,
    output logic        ls_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_e    r_state, w_state_next;
    logic [31:0]   r_addr, r_wdata, r_load_data;
    logic [2:0]    r_funct3;
    logic          r_we, r_err;
    logic [CntW-1:0] r_cnt;

    logic          w_idle, w_idle_err, w_accept, w_timeout;
    logic [31:0]   w_rdata_ext;

    assign w_idle     = (r_state == StIdle);
    assign w_idle_err = w_idle & ls_valid & access_error(funct3, ls_we, addr[1:0]);
    assign w_accept   = w_idle & ls_valid & ~w_idle_err;
    // Last permitted REQ cycle with no ack; an ack in this cycle still wins.
    assign w_timeout  = (r_state == StReq) & ~mem_ack &
                        (r_cnt == CntW'(TIMEOUT_CYCLES - 1));

    lsu_align u_align (
        .i_funct3 (r_funct3),
        .i_offset (r_addr[1:0]),
        .i_wdata  (r_wdata),
        .i_rdata  (mem_rdata),
        .o_be     (mem_be),
        .o_wdata  (mem_wdata),
        .o_rdata  (w_rdata_ext)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= StIdle;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_funct3    <= '0;
            r_we        <= 1'b0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
            r_load_data <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_addr      <= addr;
                        r_wdata     <= wdata;
                        r_funct3    <= funct3;
                        r_we        <= ls_we;
                        r_err       <= 1'b0;
                        r_cnt       <= '0;
                        r_load_data <= '0;
                    end
                end
                StReq: begin
                    r_cnt <= r_cnt + CntW'(1);
                    if (mem_ack) begin
                        r_load_data <= r_we ? '0 : w_rdata_ext;
                    end else if (w_timeout) begin
                        r_err       <= 1'b1;
                        r_load_data <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (w_accept) w_state_next = StReq;
            StReq:   if (mem_ack || w_timeout) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        mem_req   = (r_state == StReq);
        mem_we    = mem_req & r_we;
        mem_addr  = {r_addr[31:2], 2'b00};
        ls_done   = (r_state == StDone) | w_idle_err;
        ls_err    = ((r_state == StDone) & r_err) | w_idle_err;
        load_data = (r_state == StDone) ? r_load_data : '0;
        ls_stall  = ls_valid & (r_state != StDone) & ~w_idle_err;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset, ls_valid, ls_we, mem_ack;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata, mem_rdata;
    logic        ls_stall, ls_done, ls_err, mem_req, mem_we;
    logic [31:0] load_data, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    int n_checks = 0;
    int n_errors = 0;

    // Results gathered by do_access
    int          r_done_at, r_stalls, r_req;
    logic        r_err, r_we_s;
    logic [31:0] r_ld, r_wd_s, r_addr_s;
    logic [3:0]  r_be_s;

    load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .ls_valid  (ls_valid),
        .ls_we     (ls_we),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .ls_stall  (ls_stall),
        .ls_done   (ls_done),
        .load_data (load_data),
        .ls_err    (ls_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Drives one access; mem_ack pulses in cycle ack_at (cycle 0 = accept cycle).
    task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] rd, input int ack_at);
        ls_valid = 1'b1; ls_we = we; funct3 = f3; addr = a; wdata = wd; mem_rdata = rd;
        r_done_at = -1; r_stalls = 0; r_req = 0; r_err = 1'b0; r_ld = 32'hx;
        r_be_s = 4'hx; r_wd_s = 32'hx; r_addr_s = 32'hx; r_we_s = 1'bx;
        for (int i = 0; i < 40 && r_done_at < 0; i++) begin
            mem_ack = (i == ack_at);
            @(negedge clk);
            if (ls_stall) r_stalls++;
            if (mem_req) begin
                r_req++;
                r_be_s = mem_be; r_wd_s = mem_wdata; r_addr_s = mem_addr; r_we_s = mem_we;
            end
            if (ls_done) begin
                r_done_at = i; r_err = ls_err; r_ld = load_data;
            end
            next_cycle();
        end
        ls_valid = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; ls_valid = 1'b0; ls_we = 1'b0; funct3 = 3'b0; addr = '0; wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        next_cycle(); next_cycle();
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b0) begin n_errors++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
        n_checks++; if (ls_done !== 1'b0) begin n_errors++; $display("FAIL reset_done got %b exp 0", ls_done); end
        n_checks++; if (ls_err !== 1'b0) begin n_errors++; $display("FAIL reset_err got %b exp 0", ls_err); end
        n_checks++; if (load_data !== 32'h0) begin n_errors++; $display("FAIL reset_load_data got %h exp 0", load_data); end
        n_checks++; if (ls_stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall got %b exp 0", ls_stall); end
        next_cycle();
        reset = 1'b0;
        next_cycle();
    endtask

    task automatic test_store_word();
        do_access(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 3);
        n_checks++; if (r_done_at !== 4) begin n_errors++; $display("FAIL sw_done_at got %0d exp 4", r_done_at); end
        n_checks++; if (r_err !== 1'b0) begin n_errors++; $display("FAIL sw_err got %b exp 0", r_err); end
        n_checks++; if (r_stalls !== 4) begin n_errors++; $display("FAIL sw_stall_cycles got %0d exp 4", r_stalls); end
        n_checks++; if (r_req !== 3) begin n_errors++; $display("FAIL sw_req_cycles got %0d exp 3", r_req); end
        n_checks++; if (r_addr_s !== 32'h100) begin n_errors++; $display("FAIL sw_addr got %h exp 100", r_addr_s); end
        n_checks++; if (r_be_s !== 4'b1111) begin n_errors++; $display("FAIL sw_be got %b exp 1111", r_be_s); end
        n_checks++; if (r_wd_s !== 32'hDEADBEEF) begin n_errors++; $display("FAIL sw_wdata got %h exp deadbeef", r_wd_s); end
        n_checks++; if (r_we_s !== 1'b1) begin n_errors++; $display("FAIL sw_we got %b exp 1", r_we_s); end
        n_checks++; if (r_ld !== 32'h0) begin n_errors++; $display("FAIL sw_load_data got %h exp 0", r_ld); end
    endtask

    task automatic test_store_narrow();
        do_access(1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 1);
        n_checks++; if (r_done_at !== 2) begin n_errors++; $display("FAIL sb_latency got %0d exp 2", r_done_at); end
        n_checks++; if (r_be_s !== 4'b1000) begin n_errors++; $display("FAIL sb_be got %b exp 1000", r_be_s); end
        n_checks++; if (r_wd_s !== 32'hA5A5A5A5) begin n_errors++; $display("FAIL sb_wdata got %h exp a5a5a5a5", r_wd_s); end
        n_checks++; if (r_addr_s !== 32'h100) begin n_errors++; $display("FAIL sb_addr got %h exp 100", r_addr_s); end
        do_access(1'b1, 3'b001, 32'h102, 32'h1234BEEF, 32'h0, 2);
        n_checks++; if (r_be_s !== 4'b1100) begin n_errors++; $display("FAIL sh_be got %b exp 1100", r_be_s); end
        n_checks++; if (r_wd_s !== 32'hBEEFBEEF) begin n_errors++; $display("FAIL sh_wdata got %h exp beefbeef", r_wd_s); end
        n_checks++; if (r_err !== 1'b0) begin n_errors++; $display("FAIL sh_err got %b exp 0", r_err); end
    endtask

    task automatic test_loads();
        do_access(1'b0, 3'b000, 32'h202, 32'h0, 32'h12F03456, 1);
        n_checks++; if (r_ld !== 32'hFFFFFFF0) begin n_errors++; $display("FAIL lb_data got %h exp fffffff0", r_ld); end
        n_checks++; if (r_be_s !== 4'b0100) begin n_errors++; $display("FAIL lb_be got %b exp 0100", r_be_s); end
        n_checks++; if (r_we_s !== 1'b0) begin n_errors++; $display("FAIL lb_we got %b exp 0", r_we_s); end
        n_checks++; if (r_addr_s !== 32'h200) begin n_errors++; $display("FAIL lb_addr got %h exp 200", r_addr_s); end
        do_access(1'b0, 3'b100, 32'h202, 32'h0, 32'h12F03456, 1);
        n_checks++; if (r_ld !== 32'h000000F0) begin n_errors++; $display("FAIL lbu_data got %h exp 000000f0", r_ld); end
        do_access(1'b0, 3'b101, 32'h202, 32'h0, 32'h12F03456, 1);
        n_checks++; if (r_ld !== 32'h000012F0) begin n_errors++; $display("FAIL lhu_data got %h exp 000012f0", r_ld); end
        n_checks++; if (r_be_s !== 4'b1100) begin n_errors++; $display("FAIL lhu_be got %b exp 1100", r_be_s); end
        do_access(1'b0, 3'b001, 32'h200, 32'h0, 32'h00008001, 1);
        n_checks++; if (r_ld !== 32'hFFFF8001) begin n_errors++; $display("FAIL lh_data got %h exp ffff8001", r_ld); end
        do_access(1'b0, 3'b010, 32'h204, 32'h0, 32'h12F03456, 2);
        n_checks++; if (r_ld !== 32'h12F03456) begin n_errors++; $display("FAIL lw_data got %h exp 12f03456", r_ld); end
        n_checks++; if (r_addr_s !== 32'h204) begin n_errors++; $display("FAIL lw_addr got %h exp 204", r_addr_s); end
    endtask

    task automatic test_errors();
        logic [2:0]  f3s [5] = '{3'b010, 3'b100, 3'b011, 3'b001, 3'b010};
        logic        wes [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] ads [5] = '{32'h101, 32'h100, 32'h100, 32'h201, 32'h102};
        for (int k = 0; k < 5; k++) begin
            do_access(wes[k], f3s[k], ads[k], 32'h55, 32'hFFFFFFFF, 1);
            n_checks++; if (r_done_at !== 0) begin n_errors++; $display("FAIL err%0d_done_at got %0d exp 0", k, r_done_at); end
            n_checks++; if (r_err !== 1'b1) begin n_errors++; $display("FAIL err%0d_err got %b exp 1", k, r_err); end
            n_checks++; if (r_req !== 0) begin n_errors++; $display("FAIL err%0d_req got %0d exp 0", k, r_req); end
            n_checks++; if (r_stalls !== 0) begin n_errors++; $display("FAIL err%0d_stall got %0d exp 0", k, r_stalls); end
            n_checks++; if (r_ld !== 32'h0) begin n_errors++; $display("FAIL err%0d_data got %h exp 0", k, r_ld); end
        end
    endtask

    task automatic test_timeout();
        do_access(1'b0, 3'b010, 32'h300, 32'h0, 32'hFFFFFFFF, -1);
        n_checks++; if (r_done_at !== 17) begin n_errors++; $display("FAIL to_done_at got %0d exp 17", r_done_at); end
        n_checks++; if (r_req !== 16) begin n_errors++; $display("FAIL to_req_cycles got %0d exp 16", r_req); end
        n_checks++; if (r_err !== 1'b1) begin n_errors++; $display("FAIL to_err got %b exp 1", r_err); end
        n_checks++; if (r_ld !== 32'h0) begin n_errors++; $display("FAIL to_data got %h exp 0", r_ld); end
        mem_ack = 1'b1;
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b0) begin n_errors++; $display("FAIL late_ack_req got %b exp 0", mem_req); end
        n_checks++; if (ls_done !== 1'b0) begin n_errors++; $display("FAIL late_ack_done got %b exp 0", ls_done); end
        next_cycle();
        mem_ack = 1'b0;
        @(negedge clk);
        n_checks++; if (ls_done !== 1'b0 || ls_err !== 1'b0) begin n_errors++; $display("FAIL late_ack_after got done=%b err=%b exp 0/0", ls_done, ls_err); end
        next_cycle();
        do_access(1'b0, 3'b010, 32'h300, 32'h0, 32'hCAFEF00D, 16);
        n_checks++; if (r_done_at !== 17) begin n_errors++; $display("FAIL ack_at_to_done_at got %0d exp 17", r_done_at); end
        n_checks++; if (r_err !== 1'b0) begin n_errors++; $display("FAIL ack_at_to_err got %b exp 0", r_err); end
        n_checks++; if (r_ld !== 32'hCAFEF00D) begin n_errors++; $display("FAIL ack_at_to_data got %h exp cafef00d", r_ld); end
    endtask

    task automatic test_valid_drop();
        ls_valid = 1'b1; ls_we = 1'b0; funct3 = 3'b010; addr = 32'h400; mem_rdata = 32'h11223344;
        mem_ack = 1'b0;
        next_cycle();
        ls_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b1) begin n_errors++; $display("FAIL vdrop_req1 got %b exp 1", mem_req); end
        next_cycle();
        mem_ack = 1'b1;
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b1) begin n_errors++; $display("FAIL vdrop_req2 got %b exp 1", mem_req); end
        next_cycle();
        mem_ack = 1'b0;
        @(negedge clk);
        n_checks++; if (ls_done !== 1'b1) begin n_errors++; $display("FAIL vdrop_done got %b exp 1", ls_done); end
        n_checks++; if (load_data !== 32'h11223344) begin n_errors++; $display("FAIL vdrop_data got %h exp 11223344", load_data); end
        next_cycle();
    endtask

    task automatic test_reset_mid_req();
        ls_valid = 1'b1; ls_we = 1'b0; funct3 = 3'b010; addr = 32'h500; mem_rdata = 32'h99999999;
        mem_ack = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b1; ls_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b1) begin n_errors++; $display("FAIL rmid_req_before got %b exp 1", mem_req); end
        next_cycle();
        reset = 1'b0; mem_ack = 1'b1;
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b0) begin n_errors++; $display("FAIL rmid_req_after got %b exp 0", mem_req); end
        n_checks++; if (ls_done !== 1'b0 || ls_err !== 1'b0) begin n_errors++; $display("FAIL rmid_flags got done=%b err=%b exp 0/0", ls_done, ls_err); end
        n_checks++; if (load_data !== 32'h0) begin n_errors++; $display("FAIL rmid_data got %h exp 0", load_data); end
        next_cycle();
        mem_ack = 1'b0;
        @(negedge clk);
        n_checks++; if (ls_done !== 1'b0 || mem_req !== 1'b0) begin n_errors++; $display("FAIL rmid_stale_ack got done=%b req=%b exp 0/0", ls_done, mem_req); end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_store_narrow();
        test_loads();
        test_errors();
        test_timeout();
        test_valid_drop();
        test_reset_mid_req();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
